// File: rtl/alu_ctrl_pkg.sv
// Shared types and ALU control encodings for the two-requester ALU32 arbiter.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLT = 2'b10,
    OP_RAW = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } state_e;

  // {Binv, Cin, Op1, Op0}
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b1110;

  function automatic logic [3:0] op_ctl(input op_e op, input logic [3:0] raw);
    logic [3:0] ctl;
    ctl = raw;
    unique case (op)
      OP_ADD:         ctl = CTL_ADD;
      OP_SUB, OP_SLT: ctl = CTL_SUB;
      OP_RAW:         ctl = raw;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu32_arbiter_if.sv
// Request/response bus between the two requesters and the shared ALU32 arbiter.
interface alu32_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0;
  logic [1:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [3:0]  req_raw0;
  logic [3:0]  req_raw1;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_y;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_raw0, req_raw1,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_raw0, req_raw1,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu32.sv
// MIPS-style 32-bit ALU: control {Binv, Cin, Op1, Op0}; Op 00 AND, 01 OR, 10 ADD, 11 Error.
module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctl,
  output logic [31:0] y,
  output logic        zero,
  output logic        error
);
  logic [31:0] b_eff;
  logic [31:0] sum;

  always_comb begin
    b_eff = ctl[3] ? ~b : b;
    sum   = a + b_eff + {31'b0, ctl[2]};
    y     = '0;
    error = 1'b0;
    unique case (ctl[1:0])
      2'b00: y = a & b_eff;
      2'b01: y = a | b_eff;
      2'b10: y = sum;
      2'b11: error = 1'b1;
    endcase
    zero = (y == '0);
  end
endmodule

// File: rtl/alu32_arbiter.sv
// Round-robin arbiter sharing one ALU32 between two requesters; SLT takes an extra fix-up cycle.
module alu32_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu32_arbiter_if.slave bus
);
  state_e      state_q, state_d;
  logic        last_q;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [3:0]  ctl_q;
  logic        id_q;
  logic [31:0] res_y_q;
  logic        res_err_q;
  logic        rsp_id_q, rsp_zero_q, rsp_err_q;
  logic [31:0] rsp_y_q;

  logic [1:0]  grant;
  logic        win_id, accept;
  op_e         sel_op;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_raw;
  logic [31:0] alu_y;
  logic        alu_zero, alu_err;

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant = bus.req_valid;
    if (&bus.req_valid) grant = last_q ? 2'b01 : 2'b10;
  end

  assign win_id  = grant[1];
  assign accept  = (state_q == StIdle) && (|grant);
  assign sel_op  = op_e'(win_id ? bus.req_op1 : bus.req_op0);
  assign sel_a   = win_id ? bus.req_a1 : bus.req_a0;
  assign sel_b   = win_id ? bus.req_b1 : bus.req_b0;
  assign sel_raw = win_id ? bus.req_raw1 : bus.req_raw0;

  // Gated by reset so no strobe is seen while reset is held.
  assign bus.req_ready = (state_q == StIdle && reset) ? grant : 2'b00;
  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

  alu32 u_alu (
    .a     (a_q),
    .b     (b_q),
    .ctl   (ctl_q),
    .y     (alu_y),
    .zero  (alu_zero),
    .error (alu_err)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = (op_q == OP_SLT) ? StFix : StDone;
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      ctl_q      <= '0;
      id_q       <= 1'b0;
      res_y_q    <= '0;
      res_err_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b1;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            last_q <= win_id;
            id_q   <= win_id;
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            ctl_q  <= op_ctl(sel_op, sel_raw);
          end
        end
        StExec: begin
          res_y_q   <= alu_y;
          res_err_q <= alu_err;
          // Response registers only change on entry to DONE so the bus holds between results.
          if (op_q != OP_SLT) begin
            rsp_id_q   <= id_q;
            rsp_y_q    <= alu_y;
            rsp_zero_q <= alu_zero;
            rsp_err_q  <= alu_err;
          end
        end
        StFix: begin
          rsp_id_q   <= id_q;
          rsp_y_q    <= {31'b0, res_y_q[31]};
          rsp_zero_q <= ~res_y_q[31];
          rsp_err_q  <= res_err_q;
        end
        StDone: ;
      endcase
    end
  end
endmodule
